// File: rtl/vid_mem_pkg.sv
// Shared definitions for the video/CPU memory arbiter.
//   GNT_*            : 2-bit grant encoding used by the arbiter decision logic
//   DEF_ADDR_WIDTH   : default RAM word address width
//   DEF_DATA_WIDTH   : default RAM word width
package vid_mem_pkg;

    localparam logic [1:0] GNT_IDLE = 2'd0;
    localparam logic [1:0] GNT_CPU  = 2'd1;
    localparam logic [1:0] GNT_VID  = 2'd2;

    localparam int DEF_ADDR_WIDTH = 14;
    localparam int DEF_DATA_WIDTH = 16;

endpackage

// File: rtl/vid_mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between the CPU data port
// and the video scanout fetcher. Video has priority. A saturating wait
// counter gives the CPU the slot once it has been refused CPU_MAX_WAIT
// cycles in a row.
//
// Ports:
//   clk_core, reset_n            : core clock, synchronous active-low reset
//   cpu_req/we/addr/wdata        : CPU access request, held until cpu_ack
//   cpu_ack, cpu_rdata           : access done one cycle after grant
//   vid_req, vid_addr            : scanout read request
//   vid_ack                      : combinational, address taken this cycle
//   vid_valid, vid_rdata         : read data one cycle after vid_ack
//   ram_addr/we/wdata, ram_rdata : RAM macro interface, 1-cycle read latency
module vid_mem_arbiter
    import vid_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic                  clk_core,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_ack,
    output logic                  vid_valid,
    output logic [DATA_WIDTH-1:0] vid_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [7:0] MAX_WAIT = 8'(CPU_MAX_WAIT);

    logic                  r_tag_cpu;
    logic                  r_tag_vid;
    logic [7:0]            r_wait_cnt;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_vid_rdata;

    logic       w_cpu_eligible;
    logic       w_starve;
    logic [1:0] w_grant;

    // The CPU tag doubles as cpu_ack: it is registered at the grant edge and
    // is therefore high exactly in the cycle after the grant. Masking the
    // eligibility with it stops a still-held request from being re-issued.
    assign w_cpu_eligible = cpu_req & ~r_tag_cpu;
    assign w_starve       = (r_wait_cnt == MAX_WAIT);

    always_comb begin
        w_grant = GNT_IDLE;
        if (!reset_n) begin
            w_grant = GNT_IDLE;
        end else if (w_starve && w_cpu_eligible) begin
            w_grant = GNT_CPU;
        end else if (vid_req) begin
            w_grant = GNT_VID;
        end else if (w_cpu_eligible) begin
            w_grant = GNT_CPU;
        end
    end

    // Address defaults to the video side so it is deterministic when idle.
    assign ram_addr  = (w_grant == GNT_CPU) ? cpu_addr : vid_addr;
    assign ram_we    = (w_grant == GNT_CPU) & cpu_we;
    assign ram_wdata = cpu_wdata;
    assign vid_ack   = (w_grant == GNT_VID);

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            r_tag_cpu   <= 1'b0;
            r_tag_vid   <= 1'b0;
            r_wait_cnt  <= 8'd0;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
        end else begin
            r_tag_cpu <= (w_grant == GNT_CPU);
            r_tag_vid <= (w_grant == GNT_VID);

            if ((w_grant == GNT_CPU) || !w_cpu_eligible) begin
                r_wait_cnt <= 8'd0;
            end else if ((w_grant == GNT_VID) && (r_wait_cnt != MAX_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            // Hold copies keep the last delivered word on the outputs
            // once the owning tag drops.
            if (r_tag_cpu) begin
                r_cpu_rdata <= ram_rdata;
            end
            if (r_tag_vid) begin
                r_vid_rdata <= ram_rdata;
            end
        end
    end

    assign cpu_ack   = r_tag_cpu;
    assign vid_valid = r_tag_vid;
    assign cpu_rdata = r_tag_cpu ? ram_rdata : r_cpu_rdata;
    assign vid_rdata = r_tag_vid ? ram_rdata : r_vid_rdata;

endmodule

// File: tb/tb_vid_mem_arbiter.sv
module tb_vid_mem_arbiter;

    localparam int AW = 14;
    localparam int DW = 16;

    logic          clk_core = 1'b0;
    logic          reset_n;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack, vid_valid;
    logic [DW-1:0] vid_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          prev_ack = 1'b0;

    vid_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CPU_MAX_WAIT(8)) dut (
        .clk_core (clk_core),
        .reset_n  (reset_n),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_ack  (vid_ack),
        .vid_valid(vid_valid),
        .vid_rdata(vid_rdata),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk_core = ~clk_core;

    // Single-port synchronous RAM, read-before-write, one-cycle read latency.
    always @(posedge clk_core) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    function automatic logic [15:0] vdat(input int a);
        return 16'(a) ^ 16'hA5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    // Cycle-by-cycle invariants: one grant at a time, write only with a
    // CPU grant, and no back-to-back acks for a held request.
    always @(negedge clk_core) begin
        chk("mon_one_grant", 32'(vid_ack & ram_we), 32'd0);
        chk("mon_ack_gap", 32'(cpu_ack & prev_ack), 32'd0);
        prev_ack = cpu_ack;
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = vdat(i);
        ram_rdata = '0;
        reset_n   = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        vid_req   = 1'b1;
        vid_addr  = '0;

        // Reset held three edges with both requesters active.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ram_we", 32'(ram_we), 32'd0);
            chk("rst_vid_ack", 32'(vid_ack), 32'd0);
            chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
            chk("rst_vid_valid", 32'(vid_valid), 32'd0);
        end
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_vid_rdata", 32'(vid_rdata), 32'd0);

        // Release: video wins the first cycle.
        reset_n = 1'b1;
        #1;
        chk("rel_vid_ack", 32'(vid_ack), 32'd1);
        chk("rel_ram_we", 32'(ram_we), 32'd0);
        tick();
        cpu_req = 1'b0;
        vid_req = 1'b0;
        #1;
        chk("rel_vid_valid", 32'(vid_valid), 32'd1);
        chk("rel_vid_rdata", 32'(vid_rdata), 32'(vdat(0)));
        chk("rel_no_cpu_ack", 32'(cpu_ack), 32'd0);
        tick();
        chk("rel_valid_drop", 32'(vid_valid), 32'd0);
        chk("rel_rdata_hold", 32'(vid_rdata), 32'(vdat(0)));

        // CPU only: write then read back-to-back.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 14'h0123;
        cpu_wdata = 16'hBEEF;
        #1;
        chk("wr_ram_we", 32'(ram_we), 32'd1);
        chk("wr_ram_addr", 32'(ram_addr), 32'h0123);
        chk("wr_ram_wdata", 32'(ram_wdata), 32'hBEEF);
        chk("wr_vid_ack", 32'(vid_ack), 32'd0);
        tick();
        cpu_we = 1'b0;
        #1;
        chk("wr_cpu_ack", 32'(cpu_ack), 32'd1);
        chk("wr_no_regrant", 32'(ram_we), 32'd0);
        tick();
        chk("rd_cpu_ack_low", 32'(cpu_ack), 32'd0);
        chk("rd_ram_addr", 32'(ram_addr), 32'h0123);
        chk("rd_ram_we", 32'(ram_we), 32'd0);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("rd_cpu_ack", 32'(cpu_ack), 32'd1);
        chk("rd_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
        tick();
        chk("rd_ack_drop", 32'(cpu_ack), 32'd0);
        chk("rd_rdata_hold", 32'(cpu_rdata), 32'hBEEF);

        // Video streaming 0x0000..0x000F, one beat per cycle.
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) begin
                vid_req  = 1'b1;
                vid_addr = 14'(k);
            end else begin
                vid_req = 1'b0;
            end
            #1;
            if (k < 16) chk("vs_ack", 32'(vid_ack), 32'd1);
            if (k > 0) begin
                chk("vs_valid", 32'(vid_valid), 32'd1);
                chk("vs_rdata", 32'(vid_rdata), 32'(vdat(k - 1)));
            end
            tick();
        end
        chk("vs_end_valid", 32'(vid_valid), 32'd0);

        // Contention: continuous video, CPU read of 0x0200 from cycle 0.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 14'h0200;
        vid_req  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            vid_addr = 14'(14'h0040 + c);
            #1;
            chk("ct_vid_ack", 32'(vid_ack), 32'd1);
            chk("ct_cpu_ack", 32'(cpu_ack), 32'd0);
            if (c > 0) chk("ct_vid_rdata", 32'(vid_rdata), 32'(vdat(14'h0040 + c - 1)));
            tick();
        end
        vid_addr = 14'h0048;
        #1;
        chk("ct_starve_vid_ack", 32'(vid_ack), 32'd0);
        chk("ct_starve_addr", 32'(ram_addr), 32'h0200);
        chk("ct_starve_valid", 32'(vid_valid), 32'd1);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("ct_cpu_ack9", 32'(cpu_ack), 32'd1);
        chk("ct_cpu_rdata", 32'(cpu_rdata), 32'(vdat(14'h0200)));
        chk("ct_vid_resume", 32'(vid_ack), 32'd1);
        chk("ct_resume_addr", 32'(ram_addr), 32'h0048);
        chk("ct_gap_valid", 32'(vid_valid), 32'd0);
        tick();
        vid_req = 1'b0;
        #1;
        chk("ct_resume_valid", 32'(vid_valid), 32'd1);
        chk("ct_resume_rdata", 32'(vid_rdata), 32'(vdat(14'h0048)));
        tick();

        // Video idle every other cycle: CPU takes the first gap.
        cpu_req  = 1'b1;
        cpu_addr = 14'h0300;
        vid_req  = 1'b1;
        vid_addr = 14'h0010;
        #1;
        chk("gp_vid_ack0", 32'(vid_ack), 32'd1);
        tick();
        vid_req = 1'b0;
        #1;
        chk("gp_cpu_grant_addr", 32'(ram_addr), 32'h0300);
        chk("gp_vid_ack1", 32'(vid_ack), 32'd0);
        tick();
        vid_req  = 1'b1;
        vid_addr = 14'h0011;
        cpu_req  = 1'b0;
        #1;
        chk("gp_cpu_ack", 32'(cpu_ack), 32'd1);
        chk("gp_cpu_rdata", 32'(cpu_rdata), 32'(vdat(14'h0300)));
        chk("gp_vid_ack2", 32'(vid_ack), 32'd1);
        tick();
        vid_req = 1'b0;
        #1;
        chk("gp_vid_valid", 32'(vid_valid), 32'd1);
        chk("gp_vid_rdata", 32'(vid_rdata), 32'(vdat(14'h0011)));
        tick();

        // Reset mid-read: the in-flight read is dropped.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 14'h0123;
        #1;
        chk("mr_grant_addr", 32'(ram_addr), 32'h0123);
        chk("mr_grant_vid", 32'(vid_ack), 32'd0);
        reset_n = 1'b0;
        tick();
        chk("mr_no_ack", 32'(cpu_ack), 32'd0);
        chk("mr_rdata_clr", 32'(cpu_rdata), 32'd0);
        chk("mr_ram_we", 32'(ram_we), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("mr_regrant_addr", 32'(ram_addr), 32'h0123);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("mr_ack", 32'(cpu_ack), 32'd1);
        chk("mr_rdata", 32'(cpu_rdata), 32'hBEEF);
        tick();
        chk("mr_ack_drop", 32'(cpu_ack), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
